// File: rtl/pll_seq_pkg.sv
// Shared types and field geometry for the PLL register sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package pll_seq_pkg;

    typedef enum logic [1:0] {S_INIT, S_SEND, S_WAIT, S_IDLE} state_t;

    // What the current frame run is for; decides the next index after a frame.
    typedef enum logic [1:0] {M_INIT, M_WR, M_FREQ} mode_t;

    localparam int INT_W     = 12;
    localparam int FRAC_W    = 25;
    localparam int FRACL_W   = 13;  // FRAC[12:0] lives in the FREQ_LO register
    localparam int FRACH_W   = 12;  // FRAC[24:13] lives in the FREQ_HI register
    localparam int INT_LSB   = 15;
    localparam int FRACH_LSB = 3;
    localparam int FRACL_LSB = 15;

    // Power-up image, entry 0 in the most significant slice.
    localparam logic [11*32-1:0] DEFAULT_INIT_TABLE = {
        32'h0000_0007, 32'h0000_0006, 32'h0080_0006, 32'h0000_0005,
        32'h0080_0005, 32'h0018_0104, 32'h0043_0043, 32'h0700_8012,
        32'h0000_000A, 32'h0000_0001, 32'hF800_0000
    };

endpackage

// File: rtl/pll_reg_sequencer_if.sv
// Command/status bundle between sweep control (master) and the sequencer (slave).
// Latency: n/a (wires only). Requests are single-cycle pulses.
// Backpressure: none on the wires; the slave reports busy/freq_pend and drops with wr_err.
interface pll_reg_sequencer_if #(
    parameter int NUM_REGS = 11,
    parameter int REG_W    = 32
) ();
    import pll_seq_pkg::*;

    localparam int IDX_W = $clog2(NUM_REGS);

    logic               freq_req;
    logic [INT_W-1:0]   freq_int;
    logic [FRAC_W-1:0]  freq_frac;
    logic               wr_req;
    logic [IDX_W-1:0]   wr_idx;
    logic [REG_W-1:0]   wr_data;
    logic               resync_req;
    logic               busy;
    logic               init_done;
    logic               freq_pend;
    logic               wr_err;

    modport master (
        output freq_req, freq_int, freq_frac, wr_req, wr_idx, wr_data, resync_req,
        input  busy, init_done, freq_pend, wr_err
    );

    modport slave (
        input  freq_req, freq_int, freq_frac, wr_req, wr_idx, wr_data, resync_req,
        output busy, init_done, freq_pend, wr_err
    );
endinterface

// File: rtl/pll_spi_shift.sv
// 3-wire SPI frame shifter: MSB first, clock idle low, data moves on the falling edge, LE pulse after bit 0.
// Latency: busy rises the cycle after load; frame lasts (2*REG_W+2)*CLK_DIV cycles, LE ends as busy falls.
// Backpressure: load is ignored while busy; the caller must wait for busy to drop.
// Ports: clk, rst (sync, active-low), load/data in, busy out, spi_clk/spi_data/spi_le out.
module pll_spi_shift #(
    parameter int REG_W   = 32,
    parameter int CLK_DIV = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [REG_W-1:0] data,
    output logic             busy,
    output logic             spi_clk,
    output logic             spi_data,
    output logic             spi_le
);
    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int HC_W  = $clog2(2 * REG_W + 2);
    // Half periods 0..2*REG_W-1 carry the bits (odd = clock high); the last two are the LE pulse.
    localparam logic [HC_W-1:0]  LAST_BIT_HI = HC_W'(2 * REG_W - 1);
    localparam logic [HC_W-1:0]  LAST_HALF   = HC_W'(2 * REG_W + 1);
    localparam logic [DIV_W-1:0] DIV_END     = DIV_W'(CLK_DIV - 1);

    logic [DIV_W-1:0] div_cnt;
    logic [HC_W-1:0]  half_cnt;
    logic [REG_W-2:0] sh;  // bits still to be shown; the MSB goes straight to spi_data

    always_ff @(posedge clk) begin
        if (!rst) begin
            busy     <= 1'b0;
            spi_clk  <= 1'b0;
            spi_data <= 1'b0;
            spi_le   <= 1'b0;
            div_cnt  <= '0;
            half_cnt <= '0;
            sh       <= '0;
        end else if (!busy) begin
            if (load) begin
                busy     <= 1'b1;
                div_cnt  <= '0;
                half_cnt <= '0;
                spi_data <= data[REG_W-1];
                sh       <= data[REG_W-2:0];
            end
        end else if (div_cnt != DIV_END) begin
            div_cnt <= div_cnt + DIV_W'(1);
        end else begin
            div_cnt  <= '0;
            half_cnt <= half_cnt + HC_W'(1);
            if (half_cnt == LAST_HALF) begin
                busy   <= 1'b0;
                spi_le <= 1'b0;
            end else if (half_cnt == LAST_BIT_HI) begin
                spi_clk  <= 1'b0;
                spi_data <= 1'b0;
                spi_le   <= 1'b1;
            end else if (half_cnt < LAST_BIT_HI) begin
                if (half_cnt[0]) begin
                    spi_clk  <= 1'b0;
                    spi_data <= sh[REG_W-2];
                    sh       <= {sh[REG_W-3:0], 1'b0};
                end else begin
                    spi_clk <= 1'b1;
                end
            end
        end
    end
endmodule

// File: rtl/pll_reg_sequencer.sv
// Shadow register file + frame sequencer for a fractional-N PLL: power-up init, freq splice, single writes, resync.
// Latency: busy rises the cycle after a command is accepted and falls the cycle after the last frame's LE ends.
// Backpressure: freq requests queue one-deep (newest wins); wr requests while busy or out of range pulse wr_err.
// Ports: clk, rst (sync, active-low), ctl (command/status, slave side), spi_clk/spi_data/spi_le to the PLL.
module pll_reg_sequencer #(
    parameter int                          NUM_REGS   = 11,
    parameter int                          REG_W      = 32,
    parameter int                          INIT_CNT   = 8,
    parameter logic [NUM_REGS*REG_W-1:0]   INIT_TABLE = pll_seq_pkg::DEFAULT_INIT_TABLE,
    parameter int                          FREQ_HI    = 10,
    parameter int                          FREQ_LO    = 9,
    parameter int                          CLK_DIV    = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    pll_reg_sequencer_if.slave   ctl,
    output logic                 spi_clk,
    output logic                 spi_data,
    output logic                 spi_le
);
    import pll_seq_pkg::*;

    localparam int IDX_W = $clog2(NUM_REGS);

    state_t              state;
    mode_t               mode;
    logic [IDX_W-1:0]    cur_idx;
    logic [REG_W-1:0]    shadow [NUM_REGS];
    logic                load;
    logic [REG_W-1:0]    load_dat;
    logic                seen_busy;
    logic                busy, init_done, wr_err;
    logic                slot_vld;
    logic [INT_W-1:0]    slot_int;
    logic [FRAC_W-1:0]   slot_frac;
    logic                sh_busy;
    logic                wr_ok;
    logic [INT_W-1:0]    sel_int;
    logic [FRAC_W-1:0]   sel_frac;

    assign wr_ok    = int'(ctl.wr_idx) < NUM_REGS;
    // A fresh request is newer than anything sitting in the slot.
    assign sel_int  = ctl.freq_req ? ctl.freq_int  : slot_int;
    assign sel_frac = ctl.freq_req ? ctl.freq_frac : slot_frac;

    assign ctl.busy      = busy;
    assign ctl.init_done = init_done;
    assign ctl.freq_pend = slot_vld;
    assign ctl.wr_err    = wr_err;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= S_INIT;
            mode      <= M_INIT;
            cur_idx   <= '0;
            load      <= 1'b0;
            load_dat  <= '0;
            seen_busy <= 1'b0;
            busy      <= 1'b0;
            init_done <= 1'b0;
            wr_err    <= 1'b0;
            slot_vld  <= 1'b0;
            slot_int  <= '0;
            slot_frac <= '0;
            for (int k = 0; k < NUM_REGS; k++)
                shadow[k] <= INIT_TABLE[(NUM_REGS-1-k)*REG_W +: REG_W];
        end else begin
            load   <= 1'b0;
            wr_err <= 1'b0;
            // Every freq request lands in the slot; the IDLE accept below clears it when served now.
            if (ctl.freq_req) begin
                slot_vld  <= 1'b1;
                slot_int  <= ctl.freq_int;
                slot_frac <= ctl.freq_frac;
            end
            // A write is only taken in IDLE, in range, and when no resync claims the same cycle.
            if (ctl.wr_req && (state != S_IDLE || ctl.resync_req || !wr_ok))
                wr_err <= 1'b1;

            case (state)
                S_INIT: begin
                    cur_idx <= '0;
                    mode    <= M_INIT;
                    busy    <= 1'b1;
                    state   <= S_SEND;
                end
                S_SEND: begin
                    if (!sh_busy) begin
                        load      <= 1'b1;
                        load_dat  <= shadow[cur_idx];
                        seen_busy <= 1'b0;
                        state     <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    // The shifter only raises busy a cycle after load, so wait to see it rise first.
                    if (sh_busy) begin
                        seen_busy <= 1'b1;
                    end else if (seen_busy) begin
                        if (mode == M_INIT && cur_idx != IDX_W'(INIT_CNT - 1)) begin
                            cur_idx <= cur_idx + IDX_W'(1);
                            state   <= S_SEND;
                        end else if (mode == M_FREQ && cur_idx == IDX_W'(FREQ_LO)) begin
                            cur_idx <= IDX_W'(FREQ_HI);
                            state   <= S_SEND;
                        end else begin
                            if (mode == M_INIT)
                                init_done <= 1'b1;
                            busy  <= 1'b0;
                            state <= S_IDLE;
                        end
                    end
                end
                S_IDLE: begin
                    if (ctl.resync_req) begin
                        cur_idx <= '0;
                        mode    <= M_INIT;
                        busy    <= 1'b1;
                        state   <= S_SEND;
                    end else if (ctl.wr_req && wr_ok) begin
                        shadow[ctl.wr_idx] <= ctl.wr_data;
                        cur_idx <= ctl.wr_idx;
                        mode    <= M_WR;
                        busy    <= 1'b1;
                        state   <= S_SEND;
                    end else if (ctl.freq_req || slot_vld) begin
                        shadow[FREQ_LO][FRACL_LSB +: FRACL_W] <= sel_frac[FRACL_W-1:0];
                        shadow[FREQ_HI][INT_LSB +: INT_W]     <= sel_int;
                        shadow[FREQ_HI][FRACH_LSB +: FRACH_W] <= sel_frac[FRAC_W-1 -: FRACH_W];
                        slot_vld <= 1'b0;
                        cur_idx  <= IDX_W'(FREQ_LO);
                        mode     <= M_FREQ;
                        busy     <= 1'b1;
                        state    <= S_SEND;
                    end
                end
                default: state <= S_INIT;
            endcase
        end
    end

    pll_spi_shift #(
        .REG_W   (REG_W),
        .CLK_DIV (CLK_DIV)
    ) u_shift (
        .clk      (clk),
        .rst      (rst),
        .load     (load),
        .data     (load_dat),
        .busy     (sh_busy),
        .spi_clk  (spi_clk),
        .spi_data (spi_data),
        .spi_le   (spi_le)
    );
endmodule

// File: tb/tb_pll_reg_sequencer.sv
// Directed bench for pll_reg_sequencer: decodes SPI frames off the pins and compares them to hand-computed images.
// Latency: n/a (testbench).
// Backpressure: n/a (testbench).
module tb_pll_reg_sequencer;

    localparam logic [11*32-1:0] TB_TABLE = {
        32'h0000_0007, 32'h0000_0006, 32'h0080_0006, 32'h0000_0005,
        32'h0080_0005, 32'h0018_0104, 32'h0043_0043, 32'h0700_8012,
        32'h0000_000A, 32'h0000_0001, 32'hF800_0000
    };

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic spi_clk, spi_data, spi_le;

    int vec  = 0;
    int miss = 0;

    logic [31:0] tab [11];
    logic [31:0] frames [$];
    int          frame_bits [$];

    // Monitor state
    logic [31:0] acc;
    int          bits, le_cnt, le_w;
    logic        pclk, ple;

    always #5 clk = ~clk;

    pll_reg_sequencer_if #(.NUM_REGS(11), .REG_W(32)) sif ();

    pll_reg_sequencer #(
        .NUM_REGS   (11),
        .REG_W      (32),
        .INIT_CNT   (8),
        .INIT_TABLE (TB_TABLE),
        .FREQ_HI    (10),
        .FREQ_LO    (9),
        .CLK_DIV    (4)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .ctl      (sif),
        .spi_clk  (spi_clk),
        .spi_data (spi_data),
        .spi_le   (spi_le)
    );

    // Rebuild each frame from the pins: shift on spi_clk rise, close the word on spi_le rise.
    always @(negedge clk) begin
        if (!rst) begin
            acc = '0; bits = 0; le_cnt = 0; pclk = 1'b0; ple = 1'b0;
        end else begin
            if (spi_clk && !pclk) begin
                acc = {acc[30:0], spi_data};
                bits++;
            end
            if (spi_le && !ple) begin
                frames.push_back(acc);
                frame_bits.push_back(bits);
                bits = 0;
                le_cnt = 0;
            end
            if (spi_le) le_cnt++;
            if (!spi_le && ple) le_w = le_cnt;
            pclk = spi_clk;
            ple  = spi_le;
        end
    end

    task automatic pulse_freq(input logic [11:0] i, input logic [24:0] f);
        @(negedge clk);
        sif.freq_int = i; sif.freq_frac = f; sif.freq_req = 1'b1;
        @(negedge clk);
        sif.freq_req = 1'b0;
    endtask

    task automatic pulse_wr(input logic [3:0] idx, input logic [31:0] d);
        @(negedge clk);
        sif.wr_idx = idx; sif.wr_data = d; sif.wr_req = 1'b1;
        @(negedge clk);
        sif.wr_req = 1'b0;
    endtask

    task automatic wait_idle(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (!sif.busy && !sif.freq_pend) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset;
        bit ok;
        logic [31:0] got;
        repeat (3) @(negedge clk);
        vec++; if ({sif.busy, sif.init_done, sif.freq_pend, sif.wr_err} !== 4'b0000) begin
            miss++; $display("FAIL reset_status got %b want 0000", {sif.busy, sif.init_done, sif.freq_pend, sif.wr_err});
        end
        vec++; if ({spi_clk, spi_data, spi_le} !== 3'b000) begin
            miss++; $display("FAIL reset_spi got %b want 000", {spi_clk, spi_data, spi_le});
        end
        frames.delete(); frame_bits.delete();
        rst = 1'b1;
        repeat (100) @(negedge clk);
        vec++; if (sif.busy !== 1'b1 || sif.init_done !== 1'b0) begin
            miss++; $display("FAIL init_running busy=%b init_done=%b want 1/0", sif.busy, sif.init_done);
        end
        wait_idle(4000, ok);
        vec++; if (!ok) begin miss++; $display("FAIL init_timeout busy=%b", sif.busy); end
        vec++; if (frames.size() != 8) begin
            miss++; $display("FAIL init_frame_count got %0d want 8", frames.size());
        end
        for (int i = 0; i < 8; i++) begin
            got = (i < frames.size()) ? frames[i] : 32'hxxxx_xxxx;
            vec++; if (got !== tab[i]) begin
                miss++; $display("FAIL init_frame%0d got %h want %h", i, got, tab[i]);
            end
            vec++; if (i >= frame_bits.size() || frame_bits[i] != 32) begin
                miss++; $display("FAIL init_bits%0d got %0d want 32", i, (i < frame_bits.size()) ? frame_bits[i] : -1);
            end
        end
        vec++; if (le_w != 8) begin miss++; $display("FAIL le_width got %0d want 8", le_w); end
        vec++; if (sif.init_done !== 1'b1) begin
            miss++; $display("FAIL init_done got %b want 1", sif.init_done);
        end
    endtask

    task automatic test_freq;
        bit ok;
        frames.delete();
        pulse_freq(12'd100, 25'h1ABCDEF);
        vec++; if (sif.busy !== 1'b1) begin miss++; $display("FAIL freq_busy got %b want 1", sif.busy); end
        wait_idle(2000, ok);
        vec++; if (!ok || frames.size() != 2) begin
            miss++; $display("FAIL freq_frames ok=%0d got %0d want 2", ok, frames.size());
        end else begin
            vec++; if (frames[0] !== 32'h06F7_8001) begin
                miss++; $display("FAIL freq_lo got %h want 06f78001", frames[0]);
            end
            vec++; if (frames[1] !== 32'hF832_6AF0) begin
                miss++; $display("FAIL freq_hi got %h want f8326af0", frames[1]);
            end
        end
        vec++; if (sif.freq_pend !== 1'b0 || sif.busy !== 1'b0) begin
            miss++; $display("FAIL freq_after pend=%b busy=%b want 0/0", sif.freq_pend, sif.busy);
        end
    endtask

    task automatic test_wr;
        bit ok;
        frames.delete();
        pulse_wr(4'd10, 32'h0000_0008);
        wait_idle(1000, ok);
        vec++; if (!ok || frames.size() != 1 || frames[0] !== 32'h0000_0008) begin
            miss++; $display("FAIL wr_frame ok=%0d n=%0d got %h want 00000008", ok, frames.size(),
                             (frames.size() > 0) ? frames[0] : 32'hx);
        end
        frames.delete();
        pulse_freq(12'd5, 25'd0);
        repeat (10) @(negedge clk);
        pulse_wr(4'd3, 32'hDEAD_BEEF);
        vec++; if (sif.wr_err !== 1'b1) begin miss++; $display("FAIL wr_busy_err got %b want 1", sif.wr_err); end
        @(negedge clk);
        vec++; if (sif.wr_err !== 1'b0) begin miss++; $display("FAIL wr_err_pulse got %b want 0", sif.wr_err); end
        wait_idle(2000, ok);
        vec++; if (!ok || frames.size() != 2) begin
            miss++; $display("FAIL wr_freq_frames ok=%0d got %0d want 2", ok, frames.size());
        end else begin
            vec++; if (frames[0] !== 32'h0000_0001) begin
                miss++; $display("FAIL wr_freq_lo got %h want 00000001", frames[0]);
            end
            vec++; if (frames[1] !== 32'h0002_8000) begin
                miss++; $display("FAIL wr_freq_hi got %h want 00028000", frames[1]);
            end
        end
        frames.delete();
        pulse_wr(4'd11, 32'h1111_1111);
        vec++; if (sif.wr_err !== 1'b1) begin miss++; $display("FAIL wr_range_err got %b want 1", sif.wr_err); end
        repeat (10) @(negedge clk);
        vec++; if (sif.busy !== 1'b0 || frames.size() != 0) begin
            miss++; $display("FAIL wr_range_noframe busy=%b n=%0d want 0/0", sif.busy, frames.size());
        end
    endtask

    task automatic test_freq_queue;
        bit ok;
        frames.delete();
        pulse_wr(4'd8, 32'h1234_5678);
        repeat (30) @(negedge clk);
        pulse_freq(12'd1, 25'd0);
        pulse_freq(12'd2, 25'd0);
        pulse_freq(12'd3, 25'd0);
        vec++; if (sif.freq_pend !== 1'b1 || sif.busy !== 1'b1) begin
            miss++; $display("FAIL queue_pend pend=%b busy=%b want 1/1", sif.freq_pend, sif.busy);
        end
        wait_idle(2000, ok);
        vec++; if (!ok || frames.size() != 3) begin
            miss++; $display("FAIL queue_frames ok=%0d got %0d want 3", ok, frames.size());
        end else begin
            vec++; if (frames[0] !== 32'h1234_5678) begin
                miss++; $display("FAIL queue_wr got %h want 12345678", frames[0]);
            end
            vec++; if (frames[1] !== 32'h0000_0001) begin
                miss++; $display("FAIL queue_lo got %h want 00000001", frames[1]);
            end
            vec++; if (frames[2] !== 32'h0001_8000) begin
                miss++; $display("FAIL queue_hi got %h want 00018000", frames[2]);
            end
        end
    endtask

    task automatic test_simultaneous;
        bit ok;
        logic [31:0] got;
        frames.delete();
        @(negedge clk);
        sif.resync_req = 1'b1;
        sif.wr_req = 1'b1; sif.wr_idx = 4'd5; sif.wr_data = 32'h5555_5555;
        sif.freq_req = 1'b1; sif.freq_int = 12'd9; sif.freq_frac = 25'h1FFFFFF;
        @(negedge clk);
        sif.resync_req = 1'b0; sif.wr_req = 1'b0; sif.freq_req = 1'b0;
        vec++; if (sif.wr_err !== 1'b1 || sif.freq_pend !== 1'b1) begin
            miss++; $display("FAIL simul_status wr_err=%b pend=%b want 1/1", sif.wr_err, sif.freq_pend);
        end
        wait_idle(5000, ok);
        vec++; if (!ok || frames.size() != 10) begin
            miss++; $display("FAIL simul_frames ok=%0d got %0d want 10", ok, frames.size());
        end
        for (int i = 0; i < 8; i++) begin
            got = (i < frames.size()) ? frames[i] : 32'hxxxx_xxxx;
            vec++; if (got !== tab[i]) begin
                miss++; $display("FAIL resync_frame%0d got %h want %h", i, got, tab[i]);
            end
        end
        got = (frames.size() > 8) ? frames[8] : 32'hxxxx_xxxx;
        vec++; if (got !== 32'h0FFF_8001) begin miss++; $display("FAIL simul_lo got %h want 0fff8001", got); end
        got = (frames.size() > 9) ? frames[9] : 32'hxxxx_xxxx;
        vec++; if (got !== 32'h0004_FFF8) begin miss++; $display("FAIL simul_hi got %h want 0004fff8", got); end
        vec++; if (sif.init_done !== 1'b1) begin
            miss++; $display("FAIL resync_init_done got %b want 1", sif.init_done);
        end
    endtask

    task automatic test_reset_mid_frame;
        bit ok;
        bit hit;
        logic [31:0] got;
        @(negedge clk);
        sif.resync_req = 1'b1;
        @(negedge clk);
        sif.resync_req = 1'b0;
        hit = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            @(posedge clk);
            if (bits >= 16) begin hit = 1'b1; break; end
        end
        vec++; if (!hit) begin miss++; $display("FAIL midframe_timeout bits=%0d want 16", bits); end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        vec++; if ({spi_clk, spi_data, spi_le} !== 3'b000) begin
            miss++; $display("FAIL midframe_spi got %b want 000", {spi_clk, spi_data, spi_le});
        end
        vec++; if ({sif.busy, sif.init_done, sif.freq_pend} !== 3'b000) begin
            miss++; $display("FAIL midframe_status got %b want 000", {sif.busy, sif.init_done, sif.freq_pend});
        end
        frames.delete();
        @(negedge clk);
        rst = 1'b1;
        wait_idle(4000, ok);
        vec++; if (!ok || frames.size() != 8 || sif.init_done !== 1'b1) begin
            miss++; $display("FAIL reinit ok=%0d n=%0d init_done=%b want 8 frames, 1", ok, frames.size(), sif.init_done);
        end
        for (int i = 0; i < 8; i++) begin
            got = (i < frames.size()) ? frames[i] : 32'hxxxx_xxxx;
            vec++; if (got !== tab[i]) begin
                miss++; $display("FAIL reinit_frame%0d got %h want %h", i, got, tab[i]);
            end
        end
        frames.delete();
        pulse_freq(12'd0, 25'd0);
        wait_idle(2000, ok);
        got = (frames.size() > 1) ? frames[1] : 32'hxxxx_xxxx;
        vec++; if (!ok || frames.size() != 2 || frames[0] !== 32'h0000_0001 || got !== 32'hF800_0000) begin
            miss++; $display("FAIL shadow_restored n=%0d lo=%h hi=%h want 00000001 f8000000", frames.size(),
                             (frames.size() > 0) ? frames[0] : 32'hx, got);
        end
    endtask

    initial begin
        for (int k = 0; k < 11; k++) tab[k] = TB_TABLE[(10-k)*32 +: 32];
        sif.freq_req = 1'b0; sif.freq_int = '0; sif.freq_frac = '0;
        sif.wr_req = 1'b0; sif.wr_idx = '0; sif.wr_data = '0;
        sif.resync_req = 1'b0;
        le_w = 0;
        test_reset();
        test_freq();
        test_wr();
        test_freq_queue();
        test_simultaneous();
        test_reset_mid_frame();
        $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
        $finish;
    end

endmodule
